// File: rtl/pred_pkg.sv
// rtl/pred_pkg.sv - shared decode and counter constants for the next-PC predictor
package pred_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [4:0] REG_RA     = 5'd31;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch-side prediction and EX-side update signals
interface branch_predictor_if #(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8
);
    logic                if_valid;
    logic [31:0]         if_pc;
    logic [31:0]         if_instr;
    logic [31:0]         pre_pc;
    logic                pred_taken;
    logic [IDX_BITS-1:0] pred_idx;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic                upd_mispredict;
    logic [GHR_BITS-1:0] upd_ghr;

    modport master (
        output if_valid, if_pc, if_instr,
        output upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
        input  pre_pc, pred_taken, pred_idx, pred_ghr
    );

    modport slave (
        input  if_valid, if_pc, if_instr,
        input  upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
        output pre_pc, pred_taken, pred_idx, pred_ghr
    );
endinterface

// File: rtl/branch_predictor_ras_stack.sv
// rtl/branch_predictor_ras_stack.sv - circular return-address stack, oldest entry overwritten when full
module ras_stack #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ptr_q names the next free slot, so the top of stack sits one below it
    assign top   = mem_q[ptr_q - 1'b1];
    assign empty = (cnt_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH))
                cnt_d = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset)
            mem_q[ptr_q] <= push_data;
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare + RAS next-PC predictor for the IF stage
import pred_pkg::*;

module branch_predictor #(
    parameter int IDX_BITS  = 8,
    parameter int GHR_BITS  = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_EN    = 1
) (
    input logic clock,
    input logic reset,
    branch_predictor_if.slave bp
);
    localparam int PHT_SIZE = 1 << IDX_BITS;

    logic [1:0]          pht_q [PHT_SIZE];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [5:0]          opcode, funct;
    logic [4:0]          rs;
    logic                is_br, is_jmp, is_jal, is_jr31;
    logic [31:0]         seq_pc, br_pc, jt_pc, ras_top, next_pc;
    logic                ras_empty, use_ras, ras_push, ras_pop, taken;
    logic [IDX_BITS-1:0] idx;
    logic [1:0]          ctr;

    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] g, input logic t);
        return GHR_BITS'({g, t});
    endfunction

    assign opcode  = bp.if_instr[31:26];
    assign funct   = bp.if_instr[5:0];
    assign rs      = bp.if_instr[25:21];
    assign is_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jmp  = (opcode == OP_J) || is_jal;
    assign is_jr31 = (opcode == OP_SPECIAL) && (funct == FUNCT_JR) && (rs == REG_RA);

    assign seq_pc = bp.if_pc + 32'd4;
    assign br_pc  = seq_pc + {{14{bp.if_instr[15]}}, bp.if_instr[15:0], 2'b00};
    assign jt_pc  = {seq_pc[31:28], bp.if_instr[25:0], 2'b00};

    assign idx = bp.if_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign ctr = pht_q[idx];

    assign use_ras  = (RAS_EN != 0) && !ras_empty;
    assign ras_push = bp.if_valid && is_jal && (RAS_EN != 0);
    assign ras_pop  = bp.if_valid && is_jr31 && use_ras;

    always_comb begin
        next_pc = seq_pc;
        taken   = 1'b0;
        if (is_jmp) begin
            next_pc = jt_pc;
            taken   = 1'b1;
        end else if (is_jr31 && use_ras) begin
            next_pc = ras_top;
            taken   = 1'b1;
        end else if (is_br && ctr >= WT) begin
            next_pc = br_pc;
            taken   = 1'b1;
        end
    end

    assign bp.pre_pc     = next_pc;
    assign bp.pred_taken = taken;
    assign bp.pred_idx   = idx;
    assign bp.pred_ghr   = ghr_q;

    // A mispredict flushes the IF instruction, so recovery wins over its shift
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid && bp.upd_mispredict)
            ghr_d = shift_in(bp.upd_ghr, bp.upd_taken);
        else if (bp.if_valid && is_br)
            ghr_d = shift_in(ghr_q, taken);
    end

    always_ff @(posedge clock) begin
        if (reset)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHT_SIZE; i++)
                pht_q[i] <= WNT;
        end else if (bp.upd_valid) begin
            pht_q[bp.upd_idx] <= ctr_train(pht_q[bp.upd_idx], bp.upd_taken);
        end
    end

    ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    branch_predictor_if #(.IDX_BITS(8), .GHR_BITS(8)) bus ();

    branch_predictor #(.IDX_BITS(8), .GHR_BITS(8), .RAS_DEPTH(4), .RAS_EN(1)) dut (
        .clock (clock),
        .reset (reset),
        .bp    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] JR31  = 32'h03E0_0008;
    localparam logic [31:0] JR5   = 32'h00A0_0008;
    localparam logic [31:0] ADDI  = 32'h0022_1820;

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'b000100, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] bne(input logic [15:0] imm);
        return {6'b000101, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] jmp(input logic [25:0] a);
        return {6'b000010, a};
    endfunction
    function automatic logic [31:0] jal(input logic [25:0] a);
        return {6'b000011, a};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = instr;
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [7:0] idx, input logic t,
                           input logic mp, input logic [7:0] g);
        bus.upd_valid      = v;
        bus.upd_idx        = idx;
        bus.upd_taken      = t;
        bus.upd_mispredict = mp;
        bus.upd_ghr        = g;
        #1;
    endtask

    task automatic train(input logic [7:0] idx, input logic t);
        set_upd(1'b1, idx, t, 1'b0, 8'h00);
        tick();
        set_upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        set_upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        set_if(1'b1, 32'h0, beq(16'h0004));
        tick();
        chk("reset_pre_pc", bus.pre_pc, 32'h4);
        chk("reset_taken", 32'(bus.pred_taken), 32'h0);
        chk("reset_ghr", 32'(bus.pred_ghr), 32'h0);
        reset = 1'b0;

        set_if(1'b0, 32'h100, beq(16'h0004));
        chk("dflt_pre_pc", bus.pre_pc, 32'h104);
        chk("dflt_taken", 32'(bus.pred_taken), 32'h0);
        chk("dflt_idx", 32'(bus.pred_idx), 32'h40);

        train(8'h40, 1'b1);
        chk("train1_pre_pc", bus.pre_pc, 32'h114);
        chk("train1_taken", 32'(bus.pred_taken), 32'h1);
        train(8'h40, 1'b1);
        chk("train2_pre_pc", bus.pre_pc, 32'h114);
        train(8'h40, 1'b1);
        train(8'h40, 1'b0);
        chk("sat_hi_taken", 32'(bus.pred_taken), 32'h1);
        train(8'h40, 1'b0);
        chk("wnt_taken", 32'(bus.pred_taken), 32'h0);
        for (int i = 0; i < 4; i++) train(8'h40, 1'b0);
        train(8'h40, 1'b1);
        chk("sat_lo_taken", 32'(bus.pred_taken), 32'h0);
        train(8'h40, 1'b1);
        chk("retrain_taken", 32'(bus.pred_taken), 32'h1);

        set_if(1'b0, 32'h100, bne(16'h0001));
        chk("bne_pre_pc", bus.pre_pc, 32'h108);
        set_if(1'b0, 32'h100, ADDI);
        chk("alu_pre_pc", bus.pre_pc, 32'h104);
        chk("alu_taken", 32'(bus.pred_taken), 32'h0);
        set_if(1'b0, 32'h100, JR5);
        chk("jr5_pre_pc", bus.pre_pc, 32'h104);

        set_if(1'b0, 32'h0040_0010, jmp(26'h000_0040));
        chk("j_pre_pc", bus.pre_pc, 32'h100);
        chk("j_taken", 32'(bus.pred_taken), 32'h1);
        set_if(1'b0, 32'hF000_0000, jmp(26'h000_0040));
        chk("j_region", bus.pre_pc, 32'hF000_0100);

        set_if(1'b0, 32'h200, beq(16'hFFFF));
        chk("back_untrained", bus.pre_pc, 32'h204);
        train(8'h80, 1'b1);
        chk("back_trained", bus.pre_pc, 32'h200);

        set_if(1'b1, 32'h1000, jal(26'h000_0400));
        chk("jal_pre_pc", bus.pre_pc, 32'h1000);
        tick();
        set_if(1'b1, 32'h2000, JR31);
        chk("ret_pre_pc", bus.pre_pc, 32'h1004);
        chk("ret_taken", 32'(bus.pred_taken), 32'h1);
        tick();
        set_if(1'b1, 32'h3000, JR31);
        chk("ret_empty_pc", bus.pre_pc, 32'h3004);
        chk("ret_empty_taken", 32'(bus.pred_taken), 32'h0);
        tick();

        for (int i = 0; i < 5; i++) begin
            set_if(1'b1, 32'h4000 + 32'(i) * 32'h1000, jal(26'h0));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_if(1'b1, 32'hA000, JR31);
            chk("ras_lifo", bus.pre_pc, 32'h8004 - 32'(i) * 32'h1000);
            tick();
        end
        set_if(1'b1, 32'hA000, JR31);
        chk("ras_drained", bus.pre_pc, 32'hA004);
        tick();

        set_if(1'b0, 32'h9000, jal(26'h0));
        tick();
        set_if(1'b0, 32'hA000, JR31);
        chk("stall_no_push", bus.pre_pc, 32'hA004);

        set_if(1'b1, 32'h100, beq(16'h0004));
        chk("spec0_taken", 32'(bus.pred_taken), 32'h1);
        tick();
        set_if(1'b1, 32'h104, beq(16'h0004));
        chk("spec1_ghr", 32'(bus.pred_ghr), 32'h1);
        chk("spec1_idx", 32'(bus.pred_idx), 32'h40);
        tick();
        set_if(1'b1, 32'h100, beq(16'h0004));
        chk("spec2_ghr", 32'(bus.pred_ghr), 32'h3);
        set_upd(1'b1, 8'h10, 1'b0, 1'b1, 8'h01);
        tick();
        set_upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        set_if(1'b0, 32'h100, beq(16'h0004));
        chk("recover_ghr", 32'(bus.pred_ghr), 32'h2);
        chk("recover_idx", 32'(bus.pred_idx), 32'h42);

        set_upd(1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        chk("same_idx_old", 32'(bus.pred_taken), 32'h0);
        tick();
        set_upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("same_idx_new", 32'(bus.pred_taken), 32'h1);

        reset = 1'b1;
        set_upd(1'b1, 8'h40, 1'b1, 1'b0, 8'h00);
        set_if(1'b1, 32'h1000, jal(26'h0));
        tick();
        reset = 1'b0;
        set_upd(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        set_if(1'b0, 32'h100, beq(16'h0004));
        chk("rst_ghr", 32'(bus.pred_ghr), 32'h0);
        chk("rst_idx", 32'(bus.pred_idx), 32'h40);
        chk("rst_pht_taken", 32'(bus.pred_taken), 32'h0);
        chk("rst_pre_pc", bus.pre_pc, 32'h104);
        set_if(1'b0, 32'h200, JR31);
        chk("rst_ras_empty", bus.pre_pc, 32'h204);
        set_if(1'b0, 32'h108, beq(16'h0004));
        chk("rst_pht42", 32'(bus.pred_taken), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
